// File: rtl/gps_ca_pkg.sv
// ============================================================================
// gps_ca_pkg : shared constants, LFSR masks and PRN phase-select table for the
//              GPS L1 C/A code generator.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package gps_ca_pkg;

    localparam int         CA_CHIPS     = 1023;
    localparam logic [9:0] CA_LFSR_INIT = 10'h3FF;

    // Bit k-1 selects stage k: G1 = stages 3,10; G2 = stages 2,3,6,8,9,10.
    localparam logic [9:0] CA_G1_MASK   = 10'h204;
    localparam logic [9:0] CA_G2_MASK   = 10'h3A6;
    localparam logic [9:0] CA_G1_OUT    = 10'h200;

    typedef struct packed {
        logic [3:0] tap_a;
        logic [3:0] tap_b;
    } ca_taps_t;

    function automatic ca_taps_t ca_prn_taps(input logic [5:0] prn);
        logic [7:0] ab;
        ab = 8'h11;
        case (prn)
            6'd1:  ab = 8'h26;  6'd2:  ab = 8'h37;  6'd3:  ab = 8'h48;  6'd4:  ab = 8'h59;
            6'd5:  ab = 8'h19;  6'd6:  ab = 8'h2A;  6'd7:  ab = 8'h18;  6'd8:  ab = 8'h29;
            6'd9:  ab = 8'h3A;  6'd10: ab = 8'h23;  6'd11: ab = 8'h34;  6'd12: ab = 8'h56;
            6'd13: ab = 8'h67;  6'd14: ab = 8'h78;  6'd15: ab = 8'h89;  6'd16: ab = 8'h9A;
            6'd17: ab = 8'h14;  6'd18: ab = 8'h25;  6'd19: ab = 8'h36;  6'd20: ab = 8'h47;
            6'd21: ab = 8'h58;  6'd22: ab = 8'h69;  6'd23: ab = 8'h13;  6'd24: ab = 8'h46;
            6'd25: ab = 8'h57;  6'd26: ab = 8'h68;  6'd27: ab = 8'h79;  6'd28: ab = 8'h8A;
            6'd29: ab = 8'h16;  6'd30: ab = 8'h27;  6'd31: ab = 8'h38;  6'd32: ab = 8'h49;
            default: ab = 8'h11;
        endcase
        return ab;
    endfunction

    // Two distinct taps, so parity of the masked G2 state is g2[a] ^ g2[b].
    function automatic logic [9:0] ca_tap_mask(input ca_taps_t t);
        return (10'd1 << (t.tap_a - 4'd1)) | (10'd1 << (t.tap_b - 4'd1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/ca_lfsr10.sv
// ============================================================================
// ca_lfsr10 : 10-stage Fibonacci LFSR with feedback mask, load/step controls
//             and a masked-parity output tap.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

import gps_ca_pkg::*;

module ca_lfsr10 (
    input  logic       clkin,
    input  logic       rst,
    input  logic [9:0] fb_mask_i,
    input  logic [9:0] out_mask_i,
    input  logic       step_i,
    input  logic       load_i,
    output logic       out_o
);

    logic [9:0] state_q;
    logic [9:0] state_d;

    // Bit 0 is stage 1; shifting moves data toward stage 10 (bit 9).
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = CA_LFSR_INIT;
        end else if (step_i) begin
            state_d = {state_q[8:0], ^(state_q & fb_mask_i)};
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q <= CA_LFSR_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign out_o = ^(state_q & out_mask_i);

endmodule

`default_nettype wire

// File: rtl/gps_ca_code_gen.sv
// ============================================================================
// gps_ca_code_gen : GPS L1 C/A Gold-code generator advanced by chip_clk edges.
//                   CA_NAV_BIT_EN adds the 20 ms nav-bit counter (ms_cnt/bit_edge).
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

import gps_ca_pkg::*;

module gps_ca_code_gen #(
    parameter int NUM_PRN = 32,
    parameter int CHIPS   = CA_CHIPS
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       en,
    input  logic       chip_clk,
    input  logic [5:0] prn_sel,
    output logic       code_out,
    output logic [9:0] chip_idx,
    output logic       epoch,
    output logic       prn_err
`ifdef CA_NAV_BIT_EN
    ,
    output logic [4:0] ms_cnt,
    output logic       bit_edge
`endif
);

    localparam logic [9:0] c_LAST_CHIP = 10'(CHIPS - 1);
    localparam logic [5:0] c_MAX_PRN   = 6'(NUM_PRN);

    logic       chip_clk_q;
    logic [9:0] chip_idx_q, chip_idx_d;
    logic       epoch_q, epoch_d;
    logic [5:0] prn_q, prn_d;
    logic       w_adv, w_wrap;
    logic       w_g1_out, w_g2_out;
    logic [9:0] w_g2_mask;

    always_comb begin
        w_adv      = en & chip_clk & ~chip_clk_q;
        w_wrap     = w_adv & (chip_idx_q == c_LAST_CHIP);
        chip_idx_d = chip_idx_q;
        epoch_d    = 1'b0;
        prn_d      = prn_q;
        if (!en) begin
            chip_idx_d = '0;
            prn_d      = prn_sel;
        end else if (w_wrap) begin
            chip_idx_d = '0;
            epoch_d    = 1'b1;
            prn_d      = prn_sel;
        end else if (w_adv) begin
            chip_idx_d = chip_idx_q + 10'd1;
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            chip_clk_q <= 1'b0;
            chip_idx_q <= '0;
            epoch_q    <= 1'b0;
            prn_q      <= 6'd1;
        end else begin
            chip_clk_q <= chip_clk;
            chip_idx_q <= chip_idx_d;
            epoch_q    <= epoch_d;
            prn_q      <= prn_d;
        end
    end

    assign w_g2_mask = ca_tap_mask(ca_prn_taps(prn_q));

    ca_lfsr10 u_g1 (
        .clkin      (clkin),
        .rst        (rst),
        .fb_mask_i  (CA_G1_MASK),
        .out_mask_i (CA_G1_OUT),
        .step_i     (w_adv & ~w_wrap),
        .load_i     (~en | w_wrap),
        .out_o      (w_g1_out)
    );

    ca_lfsr10 u_g2 (
        .clkin      (clkin),
        .rst        (rst),
        .fb_mask_i  (CA_G2_MASK),
        .out_mask_i (w_g2_mask),
        .step_i     (w_adv & ~w_wrap),
        .load_i     (~en | w_wrap),
        .out_o      (w_g2_out)
    );

    // Invalid PRN blanks the chip but the code phase keeps running.
    assign prn_err  = (prn_q == 6'd0) | (prn_q > c_MAX_PRN);
    assign code_out = ~prn_err & (w_g1_out ^ w_g2_out);
    assign chip_idx = chip_idx_q;
    assign epoch    = epoch_q;

`ifdef CA_NAV_BIT_EN
    logic [4:0] ms_cnt_q, ms_cnt_d;
    logic       bit_edge_q, bit_edge_d;

    always_comb begin
        ms_cnt_d   = ms_cnt_q;
        bit_edge_d = 1'b0;
        if (!en) begin
            ms_cnt_d = '0;
        end else if (w_wrap) begin
            if (ms_cnt_q == 5'd19) begin
                ms_cnt_d   = '0;
                bit_edge_d = 1'b1;
            end else begin
                ms_cnt_d = ms_cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            ms_cnt_q   <= '0;
            bit_edge_q <= 1'b0;
        end else begin
            ms_cnt_q   <= ms_cnt_d;
            bit_edge_q <= bit_edge_d;
        end
    end

    assign ms_cnt   = ms_cnt_q;
    assign bit_edge = bit_edge_q;
`endif

endmodule

`default_nettype wire
